// File: rtl/hist_capture_ctrl.sv
// Capture sequencer for the pipeline signal-history shift register: arm, fill, post-trigger, freeze, dump.
// Optional trigger timeout is compiled in when HIST_TRIG_TIMEOUT_EN is defined.
module hist_capture_ctrl #(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] post_cnt_i,
    output logic             shift_en_o,
    output logic [CNT_W-1:0] fill_cnt_o,
    output logic [IDX_W-1:0] trig_idx_o,
    output logic             done_o,
    input  logic             dump_start_i,
    output logic [IDX_W-1:0] rd_idx_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic             rd_last_o,
    output logic             timeout_o
);

    if (DEPTH < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("hist_capture_ctrl: DEPTH must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_POST,
        S_DONE,
        S_DUMP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_fill_cnt;
    logic [CNT_W-1:0] r_post;
    logic [CNT_W-1:0] r_post_cnt;
    logic [IDX_W-1:0] r_trig_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [CNT_W-1:0] w_post_clamp;
    logic             w_full;
    logic             w_force;
    logic             w_trig;
    logic             w_arm;
    logic             w_dump;

    assign w_full       = (r_fill_cnt == CNT_W'(DEPTH));
    assign w_post_clamp = (post_cnt_i > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : post_cnt_i;
    assign w_trig       = (r_state == S_FILL) && (trig_i || w_force);
    assign w_dump       = (r_state == S_DONE) && dump_start_i;
    // dump_start_i beats arm_i when both arrive in DONE
    assign w_arm        = ((r_state == S_IDLE) || (r_state == S_DONE)) && arm_i && !w_dump;

`ifdef HIST_TRIG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_force = w_full && (r_to_cnt == TO_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst || abort_i || w_arm) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_FILL) begin
            if (w_trig) begin
                r_to_cnt <= '0;
                if (!trig_i) r_timeout <= 1'b1;
            end else if (w_full) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_force   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        shift_en_o = 1'b0;
        done_o     = 1'b0;
        rd_valid_o = 1'b0;
        case (r_state)
            S_IDLE: if (arm_i) w_next = S_FILL;
            S_FILL: begin
                shift_en_o = 1'b1;
                if (w_trig) w_next = (r_post != '0) ? S_POST : S_DONE;
            end
            S_POST: begin
                shift_en_o = 1'b1;
                if (r_post_cnt == CNT_W'(1)) w_next = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                if (w_dump)     w_next = S_DUMP;
                else if (w_arm) w_next = S_FILL;
            end
            S_DUMP: begin
                done_o     = 1'b1;
                rd_valid_o = 1'b1;
                if (rd_ready_i && (r_rd_idx == '0)) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort_i) w_next = S_IDLE;
        rd_last_o = (r_state == S_DUMP) && (r_rd_idx == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fill_cnt <= '0;
            r_post     <= '0;
            r_post_cnt <= '0;
            r_trig_idx <= '0;
            r_rd_idx   <= '0;
        end else if (abort_i) begin
            r_fill_cnt <= '0;
            r_trig_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_dump) r_rd_idx <= IDX_W'(r_fill_cnt - 1'b1);
                    if (w_arm) begin
                        r_fill_cnt <= '0;
                        r_post     <= w_post_clamp;
                    end
                end
                S_FILL, S_POST: begin
                    if (!w_full) r_fill_cnt <= r_fill_cnt + 1'b1;
                    if (w_trig) begin
                        r_trig_idx <= IDX_W'(r_post);
                        r_post_cnt <= r_post;
                    end else if (r_state == S_POST) begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                    end
                end
                S_DUMP: if (rd_ready_i && (r_rd_idx != '0)) r_rd_idx <= r_rd_idx - 1'b1;
                default: ;
            endcase
        end
    end

    assign fill_cnt_o = r_fill_cnt;
    assign trig_idx_o = r_trig_idx;
    assign rd_idx_o   = r_rd_idx;

endmodule

// File: tb/tb_hist_capture_ctrl.sv
// Randomized scoreboard bench for hist_capture_ctrl: capture results and dump beats are
// predicted from each capture's post value and trigger delay, then checked by a monitor.
module tb_hist_capture_ctrl;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;
`ifdef HIST_TRIG_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             arm_i = 1'b0;
    logic             abort_i = 1'b0;
    logic             trig_i = 1'b0;
    logic [CNT_W-1:0] post_cnt_i = '0;
    logic             shift_en_o;
    logic [CNT_W-1:0] fill_cnt_o;
    logic [IDX_W-1:0] trig_idx_o;
    logic             done_o;
    logic             dump_start_i = 1'b0;
    logic [IDX_W-1:0] rd_idx_o;
    logic             rd_valid_o;
    logic             rd_ready_i = 1'b0;
    logic             rd_last_o;
    logic             timeout_o;

    hist_capture_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .arm_i(arm_i), .abort_i(abort_i), .trig_i(trig_i),
        .post_cnt_i(post_cnt_i), .shift_en_o(shift_en_o), .fill_cnt_o(fill_cnt_o),
        .trig_idx_o(trig_idx_o), .done_o(done_o), .dump_start_i(dump_start_i),
        .rd_idx_o(rd_idx_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_last_o(rd_last_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct { int fill; int tidx; int shifts; bit tmo; } cap_t;
    typedef struct { int idx; bit last; } beat_t;

    cap_t  cap_q[$];
    beat_t beat_q[$];
    cap_t  mon_cap;
    beat_t mon_beat;
    int    n_cmp = 0;
    int    n_err = 0;
    int    last_fill = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scores capture completion on done_o rising and each accepted dump beat.
    int shcnt = 0;
    bit prev_done = 1'b0;
    bit stall = 1'b0;
    int stall_idx = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (done_o && !prev_done) begin
                if (cap_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_cap = cap_q.pop_front();
                    check("fill_cnt", int'(fill_cnt_o), mon_cap.fill);
                    check("trig_idx", int'(trig_idx_o), mon_cap.tidx);
                    check("shift_cycles", shcnt, mon_cap.shifts);
                    check("timeout_flag", int'(timeout_o), int'(mon_cap.tmo));
                end
            end
            if (rd_valid_o && stall) check("stall_hold_idx", int'(rd_idx_o), stall_idx);
            if (rd_valid_o && rd_ready_i) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_beat = beat_q.pop_front();
                    check("rd_idx", int'(rd_idx_o), mon_beat.idx);
                    check("rd_last", int'(rd_last_o), int'(mon_beat.last));
                end
            end
            stall     = rd_valid_o && !rd_ready_i;
            stall_idx = int'(rd_idx_o);
            shcnt     = shift_en_o ? shcnt + 1 : 0;
            prev_done = done_o;
        end else begin
            shcnt     = 0;
            prev_done = 1'b0;
            stall     = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // d = FILL cycles before the trigger cycle; expectation derived from shift count arithmetic.
    task automatic run_capture(input int post, input int d, input bit noise, input bit arm_in_post);
        cap_t c;
        int   pc;
        int   eff;
        pc    = (post > DEPTH - 1) ? DEPTH - 1 : post;
        eff   = d;
        c.tmo = 1'b0;
        if (TO_EN && d > DEPTH + TO) begin
            eff   = DEPTH + TO;
            c.tmo = 1'b1;
        end
        c.shifts  = eff + 1 + pc;
        c.fill    = (c.shifts > DEPTH) ? DEPTH : c.shifts;
        c.tidx    = pc;
        last_fill = c.fill;
        cap_q.push_back(c);
        arm_i      = 1'b1;
        post_cnt_i = CNT_W'(post);
        tick();
        arm_i      = 1'b0;
        post_cnt_i = CNT_W'($urandom);
        check("timeout_clr_on_arm", int'(timeout_o), 0);
        for (int k = 0; k < d; k++) begin
            if (noise && k < eff) begin
                arm_i        = 1'($urandom_range(0, 1));
                dump_start_i = 1'($urandom_range(0, 1));
            end
            tick();
            arm_i        = 1'b0;
            dump_start_i = 1'b0;
        end
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        if (arm_in_post && pc >= 2 && eff == d) begin
            arm_i = 1'b1;
            tick();
            arm_i = 1'b0;
        end
        for (int i = 0; i < 60 && !done_o; i++) tick();
        if (!done_o) check("done_wait", 0, 1);
    endtask

    // ready_mode 1 = toggle 1,0,1,0...; 0 = random
    task automatic do_dump(input bit with_arm, input bit ready_mode);
        beat_t b;
        for (int i = last_fill - 1; i >= 0; i--) begin
            b.idx  = i;
            b.last = (i == 0);
            beat_q.push_back(b);
        end
        dump_start_i = 1'b1;
        arm_i        = with_arm;
        tick();
        dump_start_i = 1'b0;
        arm_i        = 1'b0;
        for (int j = 0; j < 200; j++) begin
            rd_ready_i = ready_mode ? ((j % 2) == 0) : 1'($urandom_range(0, 1));
            tick();
            if (!rd_valid_o) break;
        end
        rd_ready_i = 1'b0;
        check("dump_beats_left", beat_q.size(), 0);
        check("done_after_dump", int'(done_o), 1);
        check("valid_after_dump", int'(rd_valid_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            arm_i        = 1'($urandom_range(0, 1));
            abort_i      = 1'($urandom_range(0, 1));
            trig_i       = 1'($urandom_range(0, 1));
            dump_start_i = 1'($urandom_range(0, 1));
            rd_ready_i   = 1'($urandom_range(0, 1));
            post_cnt_i   = CNT_W'($urandom);
            tick();
        end
        check("rst_shift_en", int'(shift_en_o), 0);
        check("rst_fill_cnt", int'(fill_cnt_o), 0);
        check("rst_trig_idx", int'(trig_idx_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_rd_idx", int'(rd_idx_o), 0);
        check("rst_rd_valid", int'(rd_valid_o), 0);
        check("rst_rd_last", int'(rd_last_o), 0);
        check("rst_timeout", int'(timeout_o), 0);
        arm_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0; dump_start_i = 1'b0; rd_ready_i = 1'b0;
        post_cnt_i = '0;
        rst = 1'b1;
        tick();

        run_capture(4, 20, 1'b0, 1'b0);   // late trigger
        do_dump(1'b0, 1'b1);
        run_capture(2, 3, 1'b0, 1'b0);    // early trigger, stalled dump
        do_dump(1'b0, 1'b1);
        run_capture(20, 0, 1'b0, 1'b0);   // post clamp
        do_dump(1'b0, 1'b0);
        run_capture(0, 5, 1'b0, 1'b0);    // zero post
        do_dump(1'b1, 1'b0);              // dump_start and arm together

        // Abort in POST after an ignored arm
        arm_i = 1'b1; post_cnt_i = CNT_W'(5);
        tick();
        arm_i = 1'b0; trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        tick();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("post_arm_ignored_shift", int'(shift_en_o), 1);
        check("post_arm_ignored_fill", int'(fill_cnt_o), 3);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_shift_en", int'(shift_en_o), 0);
        check("abort_fill_cnt", int'(fill_cnt_o), 0);
        check("abort_trig_idx", int'(trig_idx_o), 0);
        check("abort_done", int'(done_o), 0);
        tick();

        run_capture(3, 40, 1'b0, 1'b0);   // long wait; forced trigger when timeout is built in
        do_dump(1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_capture($urandom_range(0, 20), $urandom_range(0, 30), 1'b1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) != 0) do_dump(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-DUMP
        run_capture(5, 10, 1'b0, 1'b0);
        for (int i = last_fill - 1; i >= 0; i--) beat_q.push_back('{idx: i, last: (i == 0)});
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        rd_ready_i   = 1'b1;
        tick();
        rd_ready_i   = 1'b0;
        rst = 1'b0;
        tick();
        check("mid_dump_rst_valid", int'(rd_valid_o), 0);
        check("mid_dump_rst_done", int'(done_o), 0);
        check("mid_dump_rst_fill", int'(fill_cnt_o), 0);
        rst = 1'b1;
        beat_q.delete();
        tick();
        tick();
        check("captures_left", cap_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
